// File: rtl/dac_serial_rx_pkg.sv
// Shared constants and state encoding for the serial DAC receiver.
package dac_serial_rx_pkg;

    localparam int         FRAME_BITS_DEF = 16;
    localparam logic [7:0] CH1_ADDR       = 8'h00;
    localparam logic [7:0] CH2_ADDR       = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/dac_serial_rx_sync_edge.sv
// Multi-flop synchronizer followed by a rise/fall detector on the synchronized value.
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the asynchronous input through the chain; remember the previous synced value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/dac_serial_rx.sv
// Serial frame receiver: address+data frames shifted in on SCLK while LOAD_SHIFT is low.
module dac_serial_rx
    import dac_serial_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic       CLKOUT,
    input  logic       RST_N,
    input  logic       SCLK,
    input  logic       LOAD_SHIFT,
    input  logic       DI,
    output logic [7:0] CH1_DATA,
    output logic [7:0] CH2_DATA,
    output logic       FRAME_VALID,
    output logic [7:0] FRAME_ADDR,
    output logic       FRAME_ERR
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

    logic sclk_sync_unused, sclk_rise, sclk_fall_unused;
    logic di_sync, di_rise_unused, di_fall_unused;
    logic ls_sync, ls_rise, ls_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(CLKOUT), .rst_n(RST_N), .din(SCLK),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_di (
        .clk(CLKOUT), .rst_n(RST_N), .din(DI),
        .sync(di_sync), .rise(di_rise_unused), .fall(di_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ls (
        .clk(CLKOUT), .rst_n(RST_N), .din(LOAD_SHIFT),
        .sync(ls_sync), .rise(ls_rise), .fall(ls_fall)
    );

    state_e                state, state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic [SYNC_STAGES-1:0] warm;
    logic                  armed;
    logic                  start, sample, commit;
    logic [7:0]            addr, data;
    logic                  full;

    // The synchronizer's reset value of LOAD_SHIFT is not a real observation, so a
    // frame start is only honoured after the pin itself has been seen high.
    always_ff @(posedge CLKOUT) begin
        if (!RST_N) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            warm <= {warm[SYNC_STAGES-2:0], 1'b1};
            if (warm[SYNC_STAGES-1] && ls_sync)
                armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLKOUT) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ls_fall && armed) state_nxt = SHIFT;
            SHIFT:   if (ls_rise)          state_nxt = COMMIT;
            COMMIT:                        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // State decode: frame start clear, bit sample strobe, commit strobe.
    always_comb begin
        start  = 1'b0;
        sample = 1'b0;
        commit = 1'b0;
        case (state)
            IDLE:    start  = ls_fall & armed;
            SHIFT:   sample = sclk_rise & ~ls_sync;
            COMMIT:  commit = 1'b1;
            default: ;
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge CLKOUT) begin
        if (!RST_N || start) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (sample) begin
            shreg <= {shreg[FRAME_BITS-2:0], di_sync};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        end
    end

    assign addr = shreg[FRAME_BITS-1 -: 8];
    assign data = shreg[7:0];
    assign full = (cnt >= CNT_FULL);

    // Frame decision registered in the cycle after COMMIT.
    always_ff @(posedge CLKOUT) begin
        if (!RST_N) begin
            CH1_DATA    <= 8'h00;
            CH2_DATA    <= 8'h00;
            FRAME_ADDR  <= 8'h00;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            if (commit) begin
                FRAME_ADDR <= addr;
                if (full && addr == CH1_ADDR) begin
                    CH1_DATA    <= data;
                    FRAME_VALID <= 1'b1;
                end else if (full && addr == CH2_ADDR) begin
                    CH2_DATA    <= data;
                    FRAME_VALID <= 1'b1;
                end else begin
                    FRAME_ERR <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed + randomized bench for dac_serial_rx with a frame-level reference model.
module tb_dac_serial_rx;

    localparam int SS = 2;

    logic       CLKOUT = 1'b0;
    logic       RST_N, SCLK, LOAD_SHIFT, DI;
    logic [7:0] CH1_DATA, CH2_DATA, FRAME_ADDR;
    logic       FRAME_VALID, FRAME_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;

    logic [7:0] m_ch1, m_ch2, m_addr;

    dac_serial_rx #(.SYNC_STAGES(SS), .FRAME_BITS(16)) dut (
        .CLKOUT(CLKOUT), .RST_N(RST_N), .SCLK(SCLK), .LOAD_SHIFT(LOAD_SHIFT), .DI(DI),
        .CH1_DATA(CH1_DATA), .CH2_DATA(CH2_DATA), .FRAME_VALID(FRAME_VALID),
        .FRAME_ADDR(FRAME_ADDR), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLKOUT = ~CLKOUT;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge CLKOUT) begin
        #1;
        if (FRAME_VALID) n_valid++;
        if (FRAME_ERR) n_err++;
        if (FRAME_VALID && FRAME_ERR) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".ch1"}, {24'h0, CH1_DATA}, {24'h0, m_ch1});
        chk({tag, ".ch2"}, {24'h0, CH2_DATA}, {24'h0, m_ch2});
        chk({tag, ".addr"}, {24'h0, FRAME_ADDR}, {24'h0, m_addr});
    endtask

    // Shift the low n bits of w MSB first; SCLK half-period hp cycles; leaves LOAD_SHIFT low.
    task automatic shift_bits(input logic [31:0] w, input int n, input int hp);
        @(negedge CLKOUT);
        LOAD_SHIFT = 1'b0;
        repeat (3) @(negedge CLKOUT);
        for (int i = n - 1; i >= 0; i--) begin
            SCLK = 1'b0;
            DI   = w[i];
            repeat (hp) @(negedge CLKOUT);
            SCLK = 1'b1;
            repeat (hp) @(negedge CLKOUT);
        end
        SCLK = 1'b0;
        repeat (2) @(negedge CLKOUT);
    endtask

    // Raise LOAD_SHIFT and check the frame outcome against the model at the exact latency.
    task automatic end_frame(input string tag, input logic [31:0] w, input int n);
        logic [15:0] val;
        logic        ok, ev, ee;
        val = (n >= 16) ? w[15:0] : 16'(w & ((32'd1 << n) - 1));
        m_addr = val[15:8];
        ok = (n >= 16) && (val[15:8] == 8'h00 || val[15:8] == 8'h01);
        ev = ok;
        ee = !ok;
        if (ok && val[15:8] == 8'h00) m_ch1 = val[7:0];
        if (ok && val[15:8] == 8'h01) m_ch2 = val[7:0];
        LOAD_SHIFT = 1'b1;
        for (int k = 1; k < SS + 2; k++) begin
            @(posedge CLKOUT); #1;
            chk({tag, ".early"}, {30'h0, FRAME_VALID, FRAME_ERR}, 32'h0);
        end
        @(posedge CLKOUT); #1;
        chk({tag, ".valid"}, {31'h0, FRAME_VALID}, {31'h0, ev});
        chk({tag, ".err"}, {31'h0, FRAME_ERR}, {31'h0, ee});
        chk_outputs(tag);
        @(posedge CLKOUT); #1;
        chk({tag, ".pulse1"}, {30'h0, FRAME_VALID, FRAME_ERR}, 32'h0);
        @(negedge CLKOUT);
    endtask

    task automatic frame(input string tag, input logic [31:0] w, input int n, input int hp);
        shift_bits(w, n, hp);
        end_frame(tag, w, n);
    endtask

    initial begin
        int v0, e0, n, hp, sel;
        logic [31:0] w;
        logic [7:0]  a;

        RST_N = 1'b0; SCLK = 1'b0; DI = 1'b0; LOAD_SHIFT = 1'b1;
        m_ch1 = 8'h00; m_ch2 = 8'h00; m_addr = 8'h00;
        repeat (3) @(posedge CLKOUT);
        #1;
        chk_outputs("reset");
        chk("reset.pulses", {30'h0, FRAME_VALID, FRAME_ERR}, 32'h0);
        @(negedge CLKOUT);
        RST_N = 1'b1;
        repeat (6) @(negedge CLKOUT);

        frame("ch1_a5", 32'h00A5, 16, 4);
        frame("ch2_3c", 32'h013C, 16, 4);
        frame("ch1_5a", 32'h005A, 16, 4);
        frame("bad_addr", 32'h02FF, 16, 4);
        frame("short12", 32'h0ABC, 12, 4);
        frame("long20", 32'h9017E, 20, 4);

        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 3);
            a   = (sel == 3) ? 8'($urandom) : 8'(sel);
            n   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 20) : 16;
            hp  = $urandom_range(4, 6);
            w   = {$urandom, a, 8'($urandom)};
            w   = {w[15:0], 16'h0} >> (32 - n);
            w   = (n > 16) ? ((32'($urandom) << 16) | {16'h0, a, 8'(w[7:0])}) & ((32'd1 << n) - 1)
                           : w;
            frame($sformatf("rnd%0d", i), w, n, hp);
        end

        // Reset in the middle of a frame, pin LOAD_SHIFT still low.
        @(negedge CLKOUT);
        LOAD_SHIFT = 1'b0;
        repeat (3) @(negedge CLKOUT);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0; DI = 1'($urandom);
            repeat (4) @(negedge CLKOUT);
            SCLK = 1'b1;
            repeat (4) @(negedge CLKOUT);
        end
        v0 = n_valid; e0 = n_err;
        RST_N = 1'b0;
        @(posedge CLKOUT); #1;
        m_ch1 = 8'h00; m_ch2 = 8'h00; m_addr = 8'h00;
        chk_outputs("midrst");
        chk("midrst.pulses", {30'h0, FRAME_VALID, FRAME_ERR}, 32'h0);
        @(negedge CLKOUT);
        RST_N = 1'b1; SCLK = 1'b0;
        repeat (6) @(negedge CLKOUT);
        LOAD_SHIFT = 1'b1;
        repeat (10) @(negedge CLKOUT);
        chk("midrst.no_valid", n_valid, v0);
        chk("midrst.no_err", n_err, e0);
        chk_outputs("midrst.after");
        frame("post_rst", 32'h0011, 16, 4);

        // SCLK activity with LOAD_SHIFT high must be ignored.
        v0 = n_valid; e0 = n_err;
        for (int i = 0; i < 16; i++) begin
            SCLK = 1'b1; DI = 1'($urandom);
            repeat (4) @(negedge CLKOUT);
            SCLK = 1'b0;
            repeat (4) @(negedge CLKOUT);
        end
        repeat (SS + 4) @(negedge CLKOUT);
        chk("idle_sclk.no_valid", n_valid, v0);
        chk("idle_sclk.no_err", n_err, e0);
        chk_outputs("idle_sclk");

        frame("final_ch2", 32'h01C3, 16, 5);
        repeat (2) @(negedge CLKOUT);
        chk("never_both", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_serial_rx.md
DAC_SERIAL_RX -- requirements
Module: dac_serial_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for SCLK, DI and LOAD_SHIFT; legal values are 2 and 3.
REQ-002 Parameter FRAME_BITS, default 16, sets the bits per frame: 8 address bits followed by 8 data bits, MSB first.
REQ-003 Port CLKOUT, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 Port RST_N, input, 1 bit: reset; one clock, synchronous, active-low.
REQ-005 Port SCLK, input, 1 bit: serial bit clock, asynchronous to CLKOUT, period at least 8 CLKOUT cycles.
REQ-006 Port LOAD_SHIFT, input, 1 bit: frame enable; active-low while a frame is shifted.
REQ-007 Port DI, input, 1 bit: serial data; changes on SCLK falling edge and is stable at SCLK rising edge.
REQ-008 Port CH1_DATA, output, 8 bits: last accepted data byte for address 0x00.
REQ-009 Port CH2_DATA, output, 8 bits: last accepted data byte for address 0x01.
REQ-010 Port FRAME_VALID, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-011 Port FRAME_ADDR, output, 8 bits: address byte of the most recent complete frame, accepted or rejected.
REQ-012 Port FRAME_ERR, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-013 SCLK, DI and LOAD_SHIFT shall each pass through SYNC_STAGES flops before use; edge detection shall use the synchronized values only.
REQ-014 A sample shall be taken in the cycle where synchronized SCLK goes 0->1 while synchronized LOAD_SHIFT is 0: DI shifts into the LSB of a FRAME_BITS-bit shift register.
REQ-015 The bit counter shall increment per sample and saturate at FRAME_BITS+1; it has no wrap-around.
REQ-016 While synchronized LOAD_SHIFT is 1, SCLK edges shall be ignored, and the shift register and counter shall hold.
REQ-017 States: IDLE (LOAD_SHIFT high), SHIFT (LOAD_SHIFT low), COMMIT (one cycle). IDLE->SHIFT on the synchronized LOAD_SHIFT falling edge, which clears the counter and shift register. SHIFT->COMMIT on the synchronized LOAD_SHIFT rising edge. COMMIT->IDLE unconditionally.
REQ-018 If the LOAD_SHIFT rising edge and an SCLK rising edge are detected in the same cycle, that SCLK edge shall not be sampled.
REQ-019 In COMMIT with count >= FRAME_BITS, the last 16 bits sampled are the frame and earlier bits are discarded; bits [15:8] are the address and bits [7:0] are the data.
REQ-020 In COMMIT, an address of 0x00 updates CH1_DATA and an address of 0x01 updates CH2_DATA; FRAME_VALID is 1 in the cycle after COMMIT.
REQ-021 In COMMIT, count < FRAME_BITS or an address other than 0x00/0x01 shall leave both data outputs unchanged and pulse FRAME_ERR in the cycle after COMMIT.
REQ-022 FRAME_ADDR shall update in the same cycle as the FRAME_VALID or FRAME_ERR pulse; for a short frame it takes the zero-padded partial address.
REQ-023 FRAME_VALID and FRAME_ERR shall never be 1 in the same cycle.
REQ-024 Latency from the LOAD_SHIFT rising edge at the pin to the FRAME_VALID/FRAME_ERR pulse shall be SYNC_STAGES+2 cycles.

Reset
REQ-025 With RST_N low at a CLKOUT rising edge: CH1_DATA=0x00, CH2_DATA=0x00, FRAME_ADDR=0x00, FRAME_VALID=0, FRAME_ERR=0, state=IDLE, counter=0, shift register=0.
REQ-026 Synchronizer flops shall reset to SCLK=0, DI=0, LOAD_SHIFT=1.
REQ-027 Reset mid-frame shall discard the partial frame; after release, a frame is recognised only once LOAD_SHIFT has been seen high then falling.

Structure
REQ-028 A shared package shall hold FRAME_BITS default, CH1_ADDR=0x00, CH2_ADDR=0x01, and the state enumeration.
REQ-029 Synchronizer plus edge detect shall be one reusable sub-module, sync_edge, instantiated three times.

Verification
REQ-030 Frame addr 0x00, data 0xA5 at SCLK = CLKOUT/8 -> CH1_DATA=0xA5, FRAME_VALID pulse 1 cycle, FRAME_ADDR=0x00, CH2_DATA stays 0x00.
REQ-031 Frame addr 0x01, data 0x3C followed back-to-back by addr 0x00, data 0x5A -> CH2_DATA=0x3C then CH1_DATA=0x5A, two FRAME_VALID pulses.
REQ-032 Frame addr 0x02, data 0xFF -> FRAME_ERR pulse, FRAME_ADDR=0x02, both data outputs unchanged.
REQ-033 12-bit frame -> FRAME_ERR pulse, no data update; 20-bit frame ending in 0x01,0x7E -> CH2_DATA=0x7E.
REQ-034 RST_N low for 1 cycle after 5 bits of a frame -> all outputs at reset values, no pulse; the next full frame (0x00, 0x11) gives CH1_DATA=0x11.
REQ-035 SCLK toggling 16 times with LOAD_SHIFT high -> no pulse, outputs unchanged.
